// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between an upstream requester and the nibble-serial adder.
// The requester drives operands and start; the sequencer returns status and result.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output start, A, B, cin,
        input  busy, done, sum, co, ovf
    );

    modport slave (
        input  start, A, B, cin,
        output busy, done, sum, co, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple adder is stepped LSB nibble
// first, with the carry held in a register between passes. The result, carry-out and
// signed overflow are registered on the final pass and held until the next completion.

// 4-bit ripple-carry adder shared by the sequencer below.
module adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       co
);
    logic [4:0] c;

    // Ripple the carry through four full-adder cells.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
        end
        co = c[4];
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CntW = $clog2(NIB);
    localparam logic [CntW-1:0] LastCnt = CntW'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              co_q, co_d;
    logic              ovf_q, ovf_d;

    logic [CntW+1:0]   base;
    logic [3:0]        add_a, add_b, add_sum;
    logic              add_co;
    logic              accept;

    // Select the current operand nibbles; driven only from registered state.
    always_comb begin
        base  = {cnt_q, 2'b00};
        add_a = op_a_q[base +: 4];
        add_b = op_b_q[base +: 4];
    end

    adder u_adder (
        .A   (add_a),
        .B   (add_b),
        .cin (carry_q),
        .sum (add_sum),
        .co  (add_co)
    );

    // Next-state logic: step one nibble per RUN cycle, accept requests in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = bus.start;
            end
            StRun: begin
                acc_d[base +: 4] = add_sum;
                carry_d          = add_co;
                if (cnt_q == LastCnt) begin
                    // Final pass: publish the full result including this nibble.
                    sum_d   = acc_d;
                    co_d    = add_co;
                    ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                              (add_sum[3] != op_a_q[WIDTH-1]);
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                accept  = bus.start;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            op_a_d  = bus.A;
            op_b_d  = bus.B;
            carry_d = bus.cin;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = StRun;
        end
    end

    // State and datapath registers with synchronous, dominant reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and random checks for the nibble-serial adder sequencer (WIDTH=16).
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from an idle block, checking busy/done timing and the result.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic eo);
        bus.A = a; bus.B = b; bus.cin = ci; bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            tick();
        end
        chk({tag, "_busy3"}, 32'(bus.busy), 32'd1);
        tick();  // E4
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_co"}, 32'(bus.co), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        tick();
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, 32'(bus.sum), 32'(es));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] g;
        logic        go;
        bit          stop;

        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.cin = 1'b0;

        // Reset dominates a pending start.
        rst = 1'b1; bus.start = 1'b1; bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.cin = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_co", 32'(bus.co), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0; bus.start = 1'b0;
        tick();
        chk("rst_after_busy", 32'(bus.busy), 32'd0);

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start during RUN is ignored; captured operands and prior result are undisturbed.
        bus.A = 16'h0001; bus.B = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        tick();  // E1
        bus.A = 16'hAAAA; bus.B = 16'h5555; bus.start = 1'b1;
        tick();  // E2
        bus.start = 1'b0;
        chk("hs_hold_sum", 32'(bus.sum), 32'h8000);
        chk("hs_hold_ovf", 32'(bus.ovf), 32'd1);
        tick();  // E3
        chk("hs_busy3", 32'(bus.busy), 32'd1);
        tick();  // E4
        chk("hs_done", 32'(bus.done), 32'd1);
        chk("hs_sum", 32'(bus.sum), 32'h0002);
        chk("hs_ovf", 32'(bus.ovf), 32'd0);
        tick();
        chk("hs_idle", 32'(bus.busy), 32'd0);

        // Back-to-back: start held in the DONE cycle is accepted without an idle gap.
        bus.A = 16'h0010; bus.B = 16'h0020; bus.cin = 1'b0; bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        tick(); tick(); tick(); tick();  // E4
        chk("b2b_done1", 32'(bus.done), 32'd1);
        chk("b2b_sum1", 32'(bus.sum), 32'h0030);
        bus.A = 16'h00FF; bus.B = 16'h0001; bus.start = 1'b1;
        tick();  // E5
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_nodone", 32'(bus.done), 32'd0);
        chk("b2b_hold", 32'(bus.sum), 32'h0030);
        tick(); tick(); tick(); tick();  // E9
        chk("b2b_done2", 32'(bus.done), 32'd1);
        chk("b2b_sum2", 32'(bus.sum), 32'h0100);
        tick();

        // Reset mid-operation aborts with no done pulse and clears the result.
        bus.A = 16'h1234; bus.B = 16'h4321; bus.cin = 1'b0; bus.start = 1'b1;
        tick();  // E0
        bus.start = 1'b0;
        tick(); tick();  // E2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk("abort_nodone", 32'(bus.done), 32'd0);
            tick();
        end
        chk("abort_sum_held", 32'(bus.sum), 32'd0);

        // Random operations, each started in the previous DONE cycle.
        stop = 1'b0;
        for (int n = 0; n < 10000 && !stop; n++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            bus.A = ra; bus.B = rb; bus.cin = rc; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int k = 0; k < 8 && bus.done !== 1'b1; k++) tick();
            n_vec++;
            if (bus.done !== 1'b1) begin
                n_err++;
                $error("FAIL rnd_timeout: a=%h b=%h cin=%0d observed done=%b expected 1",
                       ra, rb, rc, bus.done);
                stop = 1'b1;
            end else begin
                g  = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
                go = (ra[15] == rb[15]) && (g[15] != ra[15]);
                n_vec++;
                assert ({bus.co, bus.sum, bus.ovf} === {g, go})
                else begin
                    n_err++;
                    $error("FAIL rnd: a=%h b=%h cin=%0d observed co=%b sum=%h ovf=%b expected co=%b sum=%h ovf=%b",
                           ra, rb, rc, bus.co, bus.sum, bus.ovf, g[16], g[15:0], go);
                    stop = 1'b1;
                end
            end
        end
        bus.start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
